// File: rtl/encoder_posicion.sv
// encoder_posicion
//   Decodes a detent quadrature encoder (A/B, rest code 11) into a saturating
//   4-bit position with sticky limit flags, plus a step pulse and direction
//   for the stepper sequencer.
// Ports:
//   clk, rst        - 50 MHz clock, asynchronous active-high reset
//   enc_a, enc_b    - raw encoder channels (asynchronous, high at detent)
//   zero            - synchronous clear of position and limit flags
//   cont_pos        - position 0..POS_MAX
//   limSUP, limINF  - CW attempted at POS_MAX / CCW attempted at 0 (sticky)
//   paso, dir       - one-cycle step pulse, direction of last detent (1=CW)
module encoder_posicion #(
  parameter int DEB_CYCLES = 250000,
  parameter int POS_MAX    = 15,
  parameter int POS_INIT   = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enc_a,
  input  logic       enc_b,
  input  logic       zero,
  output logic [3:0] cont_pos,
  output logic       limSUP,
  output logic       limINF,
  output logic       paso,
  output logic       dir
);

  localparam int              CNT_W     = $clog2(DEB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);
  localparam logic [3:0]      POS_MAX4  = 4'(POS_MAX);
  localparam logic [3:0]      POS_INIT4 = 4'(POS_INIT);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CW1  = 3'd1,
    S_CW2  = 3'd2,
    S_CW3  = 3'd3,
    S_CCW1 = 3'd4,
    S_CCW2 = 3'd5,
    S_CCW3 = 3'd6,
    S_ERR  = 3'd7
  } state_t;

  // Channel vectors are {A,B}: index 1 = A, index 0 = B.
  logic [1:0]       meta_q, meta_d;
  logic [1:0]       sync_q, sync_d;
  logic [1:0]       filt_q, filt_d;
  logic [CNT_W-1:0] deb_cnt_q [2];
  logic [CNT_W-1:0] deb_cnt_d [2];

  state_t           state_q, state_d;
  logic             cw_evt_q, cw_evt_d;
  logic             ccw_evt_q, ccw_evt_d;

  logic [3:0]       pos_q, pos_d;
  logic             lim_sup_q, lim_sup_d;
  logic             lim_inf_q, lim_inf_d;
  logic             paso_q, paso_d;
  logic             dir_q, dir_d;

  // Synchroniser and per-channel debounce. The filtered value only moves
  // after DEB_CYCLES consecutive disagreeing samples; agreement restarts it.
  always_comb begin
    meta_d = {enc_a, enc_b};
    sync_d = meta_q;
    filt_d = filt_q;
    for (int unsigned i = 0; i < 2; i++) begin
      deb_cnt_d[i] = '0;
      if (sync_q[i] != filt_q[i]) begin
        if (deb_cnt_q[i] == CNT_LAST) begin
          filt_d[i] = sync_q[i];
        end else begin
          deb_cnt_d[i] = deb_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // Decoder: a detent counts only when the full Gray sequence returns to 11
  // from the third phase; the event is registered and applied one cycle later.
  always_comb begin
    state_d   = state_q;
    cw_evt_d  = 1'b0;
    ccw_evt_d = 1'b0;
    case (state_q)
      S_IDLE:
        case (filt_q)
          2'b01:   state_d = S_CW1;
          2'b10:   state_d = S_CCW1;
          2'b00:   state_d = S_ERR;
          default: ;
        endcase
      S_CW1:
        case (filt_q)
          2'b00:   state_d = S_CW2;
          2'b11:   state_d = S_IDLE;
          2'b10:   state_d = S_ERR;
          default: ;
        endcase
      S_CW2:
        case (filt_q)
          2'b10:   state_d = S_CW3;
          2'b01:   state_d = S_CW1;
          2'b11:   state_d = S_ERR;
          default: ;
        endcase
      S_CW3:
        case (filt_q)
          2'b11: begin
            state_d  = S_IDLE;
            cw_evt_d = 1'b1;
          end
          2'b00:   state_d = S_CW2;
          2'b01:   state_d = S_ERR;
          default: ;
        endcase
      S_CCW1:
        case (filt_q)
          2'b00:   state_d = S_CCW2;
          2'b11:   state_d = S_IDLE;
          2'b01:   state_d = S_ERR;
          default: ;
        endcase
      S_CCW2:
        case (filt_q)
          2'b01:   state_d = S_CCW3;
          2'b10:   state_d = S_CCW1;
          2'b11:   state_d = S_ERR;
          default: ;
        endcase
      S_CCW3:
        case (filt_q)
          2'b11: begin
            state_d   = S_IDLE;
            ccw_evt_d = 1'b1;
          end
          2'b00:   state_d = S_CCW2;
          2'b10:   state_d = S_ERR;
          default: ;
        endcase
      S_ERR:
        if (filt_q == 2'b11) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Saturating position; zero takes priority over a simultaneous count.
  always_comb begin
    pos_d     = pos_q;
    lim_sup_d = lim_sup_q;
    lim_inf_d = lim_inf_q;
    dir_d     = dir_q;
    paso_d    = 1'b0;
    if (zero) begin
      pos_d     = POS_INIT4;
      lim_sup_d = 1'b0;
      lim_inf_d = 1'b0;
    end else if (cw_evt_q) begin
      dir_d = 1'b1;
      if (pos_q < POS_MAX4) begin
        pos_d     = pos_q + 4'd1;
        paso_d    = 1'b1;
        lim_inf_d = 1'b0;
      end else begin
        lim_sup_d = 1'b1;
      end
    end else if (ccw_evt_q) begin
      dir_d = 1'b0;
      if (pos_q != 4'd0) begin
        pos_d     = pos_q - 4'd1;
        paso_d    = 1'b1;
        lim_sup_d = 1'b0;
      end else begin
        lim_inf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q       <= '1;
      sync_q       <= '1;
      filt_q       <= '1;
      deb_cnt_q[0] <= '0;
      deb_cnt_q[1] <= '0;
      state_q      <= S_IDLE;
      cw_evt_q     <= 1'b0;
      ccw_evt_q    <= 1'b0;
      pos_q        <= POS_INIT4;
      lim_sup_q    <= 1'b0;
      lim_inf_q    <= 1'b0;
      paso_q       <= 1'b0;
      dir_q        <= 1'b0;
    end else begin
      meta_q       <= meta_d;
      sync_q       <= sync_d;
      filt_q       <= filt_d;
      deb_cnt_q[0] <= deb_cnt_d[0];
      deb_cnt_q[1] <= deb_cnt_d[1];
      state_q      <= state_d;
      cw_evt_q     <= cw_evt_d;
      ccw_evt_q    <= ccw_evt_d;
      pos_q        <= pos_d;
      lim_sup_q    <= lim_sup_d;
      lim_inf_q    <= lim_inf_d;
      paso_q       <= paso_d;
      dir_q        <= dir_d;
    end
  end

  assign cont_pos = pos_q;
  assign limSUP   = lim_sup_q;
  assign limINF   = lim_inf_q;
  assign paso     = paso_q;
  assign dir      = dir_q;

endmodule

// File: tb/tb_encoder_posicion.sv
// tb_encoder_posicion
//   Directed bench for encoder_posicion with DEB_CYCLES=4. Each stimulus step
//   updates a small behavioural model and queues the expected output change
//   with the cycle it must appear on; a negedge monitor pops and compares
//   whenever the DUT outputs change or paso is high.
module tb_encoder_posicion;

  localparam int H = 10;  // cycles each encoder code is held

  logic       clk = 1'b0;
  logic       rst;
  logic       enc_a, enc_b, zero;
  logic [3:0] cont_pos;
  logic       limSUP, limINF, paso, dir;

  encoder_posicion #(.DEB_CYCLES(4), .POS_MAX(15), .POS_INIT(0)) dut (
    .clk      (clk),
    .rst      (rst),
    .enc_a    (enc_a),
    .enc_b    (enc_b),
    .zero     (zero),
    .cont_pos (cont_pos),
    .limSUP   (limSUP),
    .limINF   (limINF),
    .paso     (paso),
    .dir      (dir)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [31:0] cyc;
    logic [7:0]  v;   // {pos[3:0], sup, inf, paso, dir}
  } exp_t;

  exp_t        sb[$];
  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  int unsigned paso_cnt = 0;

  // Reference model state
  logic [3:0] m_pos;
  logic       m_sup, m_inf, m_dir;

  // Monitor state
  logic [6:0] prev_s, cur_s;
  logic       prev_paso;
  exp_t       e;

  always @(negedge clk) begin
    if (rst) begin
      prev_s    = {cont_pos, limSUP, limINF, dir};
      prev_paso = paso;
    end else begin
      cur_s = {cont_pos, limSUP, limINF, dir};
      if (paso) begin
        paso_cnt++;
        n_cmp++;
        assert (prev_paso === 1'b0) else begin
          n_err++;
          $error("FAIL paso_width observed=%b on previous cycle, expected=0", prev_paso);
        end
      end
      if (cur_s !== prev_s || paso) begin
        n_cmp++;
        assert (sb.size() > 0) else begin
          n_err++;
          $error("FAIL unexpected_event observed=%h expected=no change (cyc %0d)",
                 {cont_pos, limSUP, limINF, paso, dir}, cyc);
        end
        if (sb.size() > 0) begin
          e = sb.pop_front();
          n_cmp++;
          assert ({cont_pos, limSUP, limINF, paso, dir} === e.v) else begin
            n_err++;
            $error("FAIL outputs observed=%b expected=%b (pos,sup,inf,paso,dir)",
                   {cont_pos, limSUP, limINF, paso, dir}, e.v);
          end
          n_cmp++;
          assert (cyc === e.cyc) else begin
            n_err++;
            $error("FAIL latency observed cycle=%0d expected cycle=%0d", cyc, e.cyc);
          end
        end
      end
      prev_s    = cur_s;
      prev_paso = paso;
    end
  end

  task automatic model_reset();
    m_pos = 4'd0; m_sup = 1'b0; m_inf = 1'b0; m_dir = 1'b0;
  endtask

  // Update the model for one complete detent whose final edge was driven at cycle n.
  task automatic model_detent(input bit cw, input int unsigned n);
    logic [6:0] old_s;
    logic       p;
    exp_t       x;
    old_s = {m_pos, m_sup, m_inf, m_dir};
    p     = 1'b0;
    if (cw) begin
      m_dir = 1'b1;
      if (m_pos != 4'd15) begin m_pos = m_pos + 4'd1; p = 1'b1; m_inf = 1'b0; end
      else m_sup = 1'b1;
    end else begin
      m_dir = 1'b0;
      if (m_pos != 4'd0) begin m_pos = m_pos - 4'd1; p = 1'b1; m_sup = 1'b0; end
      else m_inf = 1'b1;
    end
    if (p || old_s != {m_pos, m_sup, m_inf, m_dir}) begin
      x.cyc = n + 8;  // 2 sync + 4 debounce + 1 FSM + 1 counter
      x.v   = {m_pos, m_sup, m_inf, p, m_dir};
      sb.push_back(x);
    end
  endtask

  task automatic step(input logic [1:0] code, input int unsigned hold);
    @(posedge clk); #1;
    {enc_a, enc_b} = code;
    repeat (hold - 1) @(posedge clk);
  endtask

  task automatic detent(input bit cw);
    step(cw ? 2'b01 : 2'b10, H);
    step(2'b00, H);
    step(cw ? 2'b10 : 2'b01, H);
    @(posedge clk); #1;
    {enc_a, enc_b} = 2'b11;
    model_detent(cw, cyc);
    repeat (H - 1) @(posedge clk);
  endtask

  task automatic pulse_zero();
    logic [6:0] old_s;
    exp_t       x;
    @(posedge clk); #1;
    zero  = 1'b1;
    old_s = {m_pos, m_sup, m_inf, m_dir};
    m_pos = 4'd0; m_sup = 1'b0; m_inf = 1'b0;
    if (old_s != {m_pos, m_sup, m_inf, m_dir}) begin
      x.cyc = cyc + 1;
      x.v   = {m_pos, m_sup, m_inf, 1'b0, m_dir};
      sb.push_back(x);
    end
    @(posedge clk); #1;
    zero = 1'b0;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 60 && sb.size() != 0; i++) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    assert (sb.size() == 0) else begin
      n_err++;
      $error("FAIL %s_drain observed pending=%0d expected=0", tag, sb.size());
    end
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  int unsigned paso0;

  initial begin
    rst = 1'b1; enc_a = 1'b1; enc_b = 1'b1; zero = 1'b0;
    model_reset();
    #2;
    check("reset_pos",  {4'd0, cont_pos}, 8'd0);
    check("reset_flags", {4'd0, limSUP, limINF, paso, dir}, 8'd0);
    #20 rst = 1'b0;

    // 1: asynchronous reset mid-detent
    detent(1'b1);
    drain("t1_pre");
    check("t1_pre_pos", {4'd0, cont_pos}, 8'd1);
    step(2'b01, H);
    step(2'b00, 3);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    check("t1_async_pos", {4'd0, cont_pos}, 8'd0);
    check("t1_async_flags", {5'd0, limSUP, limINF, paso}, 8'd0);
    {enc_a, enc_b} = 2'b11;
    sb.delete();
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (5) @(posedge clk);

    // 2: three CW detents with latency checked per update
    paso0 = paso_cnt;
    repeat (3) detent(1'b1);
    drain("t2");
    check("t2_paso_count", 8'(paso_cnt - paso0), 8'd3);
    check("t2_pos_dir", {3'd0, cont_pos, dir}, {3'd0, 4'd3, 1'b1});

    // 3: saturation at POS_MAX and release by one CCW step
    pulse_zero();
    repeat (15) detent(1'b1);
    drain("t3a");
    check("t3_pos15", {3'd0, cont_pos, limSUP}, {3'd0, 4'd15, 1'b0});
    paso0 = paso_cnt;
    detent(1'b1);
    drain("t3b");
    check("t3_limsup", {3'd0, cont_pos, limSUP}, {3'd0, 4'd15, 1'b1});
    check("t3_no_paso", 8'(paso_cnt - paso0), 8'd0);
    detent(1'b0);
    drain("t3c");
    check("t3_ccw", {3'd0, cont_pos, limSUP}, {3'd0, 4'd14, 1'b0});

    // 4: CCW at zero sets limINF, zero clears it
    pulse_zero();
    detent(1'b0);
    drain("t4a");
    check("t4_liminf", {3'd0, cont_pos, limINF}, {3'd0, 4'd0, 1'b1});
    pulse_zero();
    drain("t4b");
    check("t4_cleared", {6'd0, limSUP, limINF}, 8'd0);

    // 5: 3-cycle glitch on A, then abandoned 11-01-11
    paso0 = paso_cnt;
    @(posedge clk); #1;
    enc_a = 1'b0;
    repeat (3) @(posedge clk);
    #1 enc_a = 1'b1;
    repeat (20) @(posedge clk);
    step(2'b01, H);
    step(2'b11, H);
    repeat (20) @(posedge clk);
    drain("t5");
    check("t5_pos", {4'd0, cont_pos}, 8'd0);
    check("t5_no_paso", 8'(paso_cnt - paso0), 8'd0);

    // 6: illegal jump 11-00-11, then a normal CW detent
    step(2'b00, H);
    step(2'b11, H);
    repeat (20) @(posedge clk);
    drain("t6a");
    check("t6_err_pos", {4'd0, cont_pos}, 8'd0);
    detent(1'b1);
    drain("t6b");
    check("t6_recover", {3'd0, cont_pos, dir}, {3'd0, 4'd1, 1'b1});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "timeout");
  end

endmodule
